// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_A = 2'b01,
    SERVE_B = 2'b10
  } arb_state_e;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mux2_data.sv
// WIDTH-bit 2:1 data mux, y = s ? a : b.
module mux2_data #(
  parameter int WIDTH = 8
) (
  input  logic             s_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = s_i ? a_i : b_i;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink between requesters A and B.
// Define MUX2_ARB_LOCK_EN to add a_lock/b_lock and a bounded grant-hold counter.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_gnt,
  input  logic             b_req,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_gnt,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
`ifdef MUX2_ARB_LOCK_EN
  input  logic             a_lock,
  input  logic             b_lock,
`endif
  output arb_state_e       dbg_state
);

  // Handshake: a beat completes on out_valid & out_ready; the granted producer
  // reads x_gnt & out_ready as acceptance, and must hold data while not ready.

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       keep_a, keep_b;

`ifdef MUX2_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  // A locked holder keeps the grant only while this beat leaves it under LOCK_MAX.
  assign cnt_inc = (int'(cnt_q) >= LOCK_MAX) ? cnt_q : cnt_q + CW'(1);
  assign keep_a  = a_lock && ((int'(cnt_q) + 1) < LOCK_MAX);
  assign keep_b  = b_lock && ((int'(cnt_q) + 1) < LOCK_MAX);
`else
  assign keep_a  = 1'b0;
  assign keep_b  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (a_req && (!b_req || last_q == SEL_B)) state_d = SERVE_A;
        else if (b_req)                           state_d = SERVE_B;
      end
      SERVE_A: begin
        if (!a_req) begin
          state_d = IDLE;
        end else if (out_ready) begin
          last_d  = SEL_A;
          state_d = (b_req && !keep_a) ? SERVE_B : SERVE_A;
        end
      end
      SERVE_B: begin
        if (!b_req) begin
          state_d = IDLE;
        end else if (out_ready) begin
          last_d  = SEL_B;
          state_d = (a_req && !keep_b) ? SERVE_A : SERVE_B;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MUX2_ARB_LOCK_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE || state_d != state_q) cnt_d = '0;
    else if (out_valid && out_ready)           cnt_d = cnt_inc;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SEL_B;
`ifdef MUX2_ARB_LOCK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
`ifdef MUX2_ARB_LOCK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign a_gnt     = (state_q == SERVE_A);
  assign b_gnt     = (state_q == SERVE_B);
  assign sel       = a_gnt ? SEL_A : SEL_B;
  assign out_valid = (a_gnt & a_req) | (b_gnt & b_req);
  assign dbg_state = state_q;

  mux2_data #(.WIDTH(WIDTH)) u_data (
    .s_i (sel),
    .a_i (a_data),
    .b_i (b_data),
    .y_o (out_data)
  );

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: per-cycle reference model plus literal checks.
module tb_mux2_arbiter;
  import mux2_arb_pkg::*;

  localparam int WIDTH    = 8;
  localparam int LOCK_MAX = 4;
`ifdef MUX2_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_req, b_req, out_ready, a_lock, b_lock;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_gnt, b_gnt, sel, out_valid;
  logic [WIDTH-1:0] out_data;
  arb_state_e       dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  bit sb_on = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  mux2_arbiter #(.WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_data    (a_data),
    .a_gnt     (a_gnt),
    .b_req     (b_req),
    .b_data    (b_data),
    .b_gnt     (b_gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
`ifdef MUX2_ARB_LOCK_EN
    .a_lock    (a_lock),
    .b_lock    (b_lock),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish / required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // holder: 0 = nobody, 1 = A, 2 = B; last: who completed the most recent beat;
  // run: consecutive completed beats of the current holder.
  typedef struct packed {
    logic [1:0] holder;
    logic [1:0] last;
    logic [3:0] run;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t cur, logic ar, logic br,
                                        logic al, logic bl, logic rdy);
    model_t nx = cur;
    logic mine_req, other_req, mine_lock;
    int served;
    if (cur.holder == 2'd0) begin
      nx.run = 4'd0;
      if (ar && br)  nx.holder = (cur.last == 2'd2) ? 2'd1 : 2'd2;
      else if (ar)   nx.holder = 2'd1;
      else if (br)   nx.holder = 2'd2;
    end else begin
      mine_req  = (cur.holder == 2'd1) ? ar : br;
      other_req = (cur.holder == 2'd1) ? br : ar;
      mine_lock = LOCK_ON && ((cur.holder == 2'd1) ? al : bl);
      if (!mine_req) begin
        nx.holder = 2'd0;
        nx.run    = 4'd0;
      end else if (rdy) begin
        nx.last = cur.holder;
        served  = (int'(cur.run) + 1 > LOCK_MAX) ? LOCK_MAX : int'(cur.run) + 1;
        if (mine_lock && served < LOCK_MAX) begin
          nx.run = 4'(served);
        end else if (other_req) begin
          nx.holder = 2'd3 - cur.holder;
          nx.run    = 4'd0;
        end else begin
          nx.run = 4'(served);
        end
      end
    end
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{holder: 2'd0, last: 2'd2, run: 4'd0};
    else        m <= model_step(m, a_req, b_req, a_lock, b_lock, out_ready);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n !== 1'bx) begin
      check("cyc_a_gnt", 32'(a_gnt), 32'(m.holder == 2'd1));
      check("cyc_b_gnt", 32'(b_gnt), 32'(m.holder == 2'd2));
      check("cyc_sel", 32'(sel), 32'(m.holder == 2'd1));
      check("cyc_out_valid", 32'(out_valid),
            32'((m.holder == 2'd1 && a_req) || (m.holder == 2'd2 && b_req)));
      check("cyc_out_data", 32'(out_data), 32'((m.holder == 2'd1) ? a_data : b_data));
    end
    if (sb_on && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_beat", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        check("sb_beat_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_a_gnt"}, 32'(a_gnt), 32'd0);
    check({tag, "_b_gnt"}, 32'(b_gnt), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_sel"}, 32'(sel), 32'd0);
  endtask

  logic exp_lock [6];

  initial begin
    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; out_ready = 1'b0;
    a_lock = 1'b0; b_lock = 1'b0; a_data = '0; b_data = '0;
    repeat (2) nxt();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    nxt();

    // single requester B
    b_req = 1'b1; b_data = 8'h5A; out_ready = 1'b1;
    nxt();
    check("single_b_gnt", 32'(b_gnt), 32'd1);
    check("single_sel", 32'(sel), 32'd0);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h5A);
    nxt();
    check("single_hold_b_gnt", 32'(b_gnt), 32'd1);
    b_req = 1'b0;
    nxt();
    check_idle_outputs("single_end");

    // contention: strict alternation starting with A
    a_data = 8'hA1; b_data = 8'hB2;
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 8'hA1 : 8'hB2);
    sb_on = 1'b1; a_req = 1'b1; b_req = 1'b1;
    repeat (6) nxt();
    sb_on = 1'b0;
    check("contention_left", 32'(exp_q.size()), 32'd0);
    a_req = 1'b0; b_req = 1'b0;
    nxt();

    // backpressure on A, then hand-over to B
    out_ready = 1'b0; a_req = 1'b1; a_data = 8'h3C;
    nxt();
    check("bp_a_gnt", 32'(a_gnt), 32'd1);
    check("bp_data", 32'(out_data), 32'h3C);
    b_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      check("bp_hold_a_gnt", 32'(a_gnt), 32'd1);
      check("bp_hold_b_gnt", 32'(b_gnt), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    nxt();
    check("bp_then_b_gnt", 32'(b_gnt), 32'd1);
    check("bp_then_data", 32'(out_data), 32'hB2);

    // drop: leave last = B, grant A, drop a_req mid-beat
    a_req = 1'b0;
    nxt();
    b_req = 1'b0; a_req = 1'b1; out_ready = 1'b0;
    nxt();
    check_idle_outputs("drop_b_idle");
    nxt();
    check("drop_a_gnt", 32'(a_gnt), 32'd1);
    a_req = 1'b0;
    nxt();
    check_idle_outputs("drop_idle");
    a_req = 1'b1; b_req = 1'b1;
    nxt();
    check("drop_regrant_a", 32'(a_gnt), 32'd1);
    check("drop_regrant_sel", 32'(sel), 32'd1);

    // reset mid-beat while last = A
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0; b_req = 1'b0;
    nxt();
    nxt();
    check("rst_pre_a_gnt", 32'(a_gnt), 32'd1);
    b_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    repeat (2) nxt();
    rst_n = 1'b1; out_ready = 1'b1;
    nxt();
    check("rst_first_a_gnt", 32'(a_gnt), 32'd1);
    check("rst_first_sel", 32'(sel), 32'd1);

`ifdef MUX2_ARB_LOCK_EN
    // lock: A holds LOCK_MAX beats, then B, then A
    exp_lock = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rst_n = 1'b0;
    nxt();
    a_lock = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nxt();
      check("lock_a_gnt", 32'(a_gnt), 32'(exp_lock[i]));
      check("lock_b_gnt", 32'(b_gnt), 32'(!exp_lock[i]));
    end
    a_lock = 1'b0;
`endif

    a_req = 1'b0; b_req = 1'b0;
    nxt();
    check_idle_outputs("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
